serial_add_ctrl: RTL and testbench

Sequencer that time-shares one 1-bit full adder cell to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock. A requester supplies operands and carry-in with a start pulse. The block runs WIDTH add cycles and returns sum and carry-out with a one-cycle done strobe. It is the area-minimal adder option for slow-path arithmetic.

---
 rtl/serial_add_ctrl_pkg.sv | 7 +
 rtl/serial_add_ctrl_fa.sv | 11 +
 rtl/serial_add_ctrl.sv | 73 +++++++
 tb/tb_serial_add_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding and default width for the bit-serial adder
package serial_add_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_add_ctrl_fa.sv
// serial_add_ctrl_fa: combinational 1-bit full adder cell shared across all bit positions
module serial_add_ctrl_fa (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic c
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands LSB first through one full adder, one bit per clock
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             fa_sum, fa_carry, accept, run, last;
  logic [WIDTH:0]   acc_cat;
  serial_add_ctrl_fa u_fa (
    .sum  (fa_sum),
    .carry(fa_carry),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c    (carry_q)
  );
  // new sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts
  always_comb begin
    accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    run     = state_q == ST_RUN;
    last    = run && cnt_q == LAST;
    acc_cat = {fa_sum, acc_q};
    state_d = accept ? ST_RUN : last ? ST_DONE : run ? ST_RUN : ST_IDLE;
    a_sh_d  = accept ? a_in : run ? a_sh_q >> 1 : a_sh_q;
    b_sh_d  = accept ? b_in : run ? b_sh_q >> 1 : b_sh_q;
    carry_d = accept ? cin : run ? fa_carry : carry_q;
    acc_d   = accept ? '0 : run ? acc_cat[WIDTH:1] : acc_q;
    cnt_d   = accept ? '0 : run ? cnt_q + CNT_W'(1) : cnt_q;
    sum_d   = last ? acc_cat[WIDTH:1] : sum_q;
    cout_d  = last ? fa_carry : cout_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy    = state_q == ST_RUN;
  assign done    = state_q == ST_DONE;
  assign sum_out = sum_q;
  assign cout    = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of the bit-serial adder at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       start = 1'b0, cin = 1'b0, busy, done, cout;
  logic [7:0] a_in = '0, b_in = '0, sum_out;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, busy1, done1, sum1, cout1;
  int passed = 0, total = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output int lat, output int busy_n);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (sum_out !== 8'h00) $display("FAIL reset_sum got %h want 00", sum_out); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, bn;
    add8(8'h5A, 8'h3C, 1'b0, lat, bn);
    total++; if (lat !== 9) $display("FAIL basic_latency got %0d want 9", lat); else passed++;
    total++; if (bn !== 8) $display("FAIL basic_busy_cycles got %0d want 8", bn); else passed++;
    total++; if ({cout, sum_out} !== 9'h096) $display("FAIL basic_result got %b_%h want 0_96", cout, sum_out); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL basic_done_one_cycle got %b want 0", done); else passed++;
    total++; if (sum_out !== 8'h96) $display("FAIL basic_sum_hold got %h want 96", sum_out); else passed++;
  endtask

  task automatic test_carry();
    int lat, bn;
    add8(8'hFF, 8'h01, 1'b0, lat, bn);
    total++; if ({cout, sum_out} !== 9'h100) $display("FAIL carry_ff_01 got %b_%h want 1_00", cout, sum_out); else passed++;
    tick();
    add8(8'hFF, 8'hFF, 1'b1, lat, bn);
    total++; if ({cout, sum_out} !== 9'h1FF) $display("FAIL carry_ff_ff_1 got %b_%h want 1_ff", cout, sum_out); else passed++;
    total++; if (lat !== 9) $display("FAIL carry_latency got %0d want 9", lat); else passed++;
    tick();
  endtask

  task automatic test_start_in_run();
    int n = 1, dones = 0;
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    a_in = 8'h11; b_in = 8'h22;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    start = 1'b0;
    total++; if (n !== 9) $display("FAIL ignore_latency got %0d want 9", n); else passed++;
    total++; if ({cout, sum_out} !== 9'h030) $display("FAIL ignore_result got %b_%h want 0_30", cout, sum_out); else passed++;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL ignore_extra_done got %0d want 0", dones); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ignore_busy_after got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int n = 1;
    logic b2b_busy = 1'b0;
    a_in = 8'h40; b_in = 8'h03; cin = 1'b0; start = 1'b1;
    tick();
    while (!done && n < 40) begin
      tick();
      n++;
    end
    total++; if ({cout, sum_out} !== 9'h043) $display("FAIL b2b_first got %b_%h want 0_43", cout, sum_out); else passed++;
    a_in = 8'h01; b_in = 8'h01;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        b2b_busy = busy;
        start = 1'b0;
      end
    end while (!done && n < 40);
    total++; if (b2b_busy !== 1'b1) $display("FAIL b2b_no_bubble got %b want 1", b2b_busy); else passed++;
    total++; if (n !== 9) $display("FAIL b2b_spacing got %0d want 9", n); else passed++;
    total++; if ({cout, sum_out} !== 9'h002) $display("FAIL b2b_second got %b_%h want 0_02", cout, sum_out); else passed++;
    tick();
  endtask

  task automatic test_abort();
    int lat, bn, dones = 0;
    a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    total++; if (sum_out !== 8'h00) $display("FAIL abort_sum got %h want 00", sum_out); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL abort_cout got %b want 0", cout); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones); else passed++;
    add8(8'h12, 8'h34, 1'b1, lat, bn);
    total++; if ({cout, sum_out} !== 9'h047) $display("FAIL abort_fresh got %b_%h want 0_47", cout, sum_out); else passed++;
    total++; if (lat !== 9) $display("FAIL abort_fresh_latency got %0d want 9", lat); else passed++;
    tick();
  endtask

  task automatic test_width1();
    logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] v;
    int n;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 1;
      while (!done1 && n < 20) begin
        tick();
        n++;
      end
      total++; if (n !== 2) $display("FAIL w1_latency abc=%b got %0d want 2", v, n); else passed++;
      total++; if ({cout1, sum1} !== fa_tab[i]) $display("FAIL w1_result abc=%b got %b want %b", v, {cout1, sum1}, fa_tab[i]); else passed++;
      tick();
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_carry();
    test_start_in_run();
    test_back_to_back();
    test_abort();
    test_width1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
